// File: rtl/cmd_byte_assembler_if.sv
// Bus bundle for cmd_byte_assembler: UART rx byte handshake, assembled
// command handshake and response transmit handshake.
`timescale 1ns/1ps
interface cmd_byte_assembler_if;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic        resp_sent;
    logic        frame_err;

    modport master (
        output rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
        input  clr_rx_rdy, cmd, cmd_rdy, tx_data, trmt, resp_sent,
               frame_err
    );

    modport slave (
        input  rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
        output clr_rx_rdy, cmd, cmd_rdy, tx_data, trmt, resp_sent,
               frame_err
    );
endinterface

// File: rtl/cmd_byte_assembler.sv
// Pairs received bytes into 16-bit commands and runs the response transmit
// handshake. Define CMD_TIMEOUT_EN to build the inter-byte timeout.
`timescale 1ns/1ps
module cmd_byte_assembler #(
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic                 clk,
    input  logic                 rst,
    cmd_byte_assembler_if.slave  bus
);
    typedef enum logic {WAIT_HI, WAIT_LO} rx_state_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    rx_state_t   rx_state, rx_state_nxt;
    tx_state_t   tx_state, tx_state_nxt;
    logic [15:0] cmd_q, cmd_nxt;
    logic        cmd_rdy_q, cmd_rdy_nxt;
    logic        clr_rx_q, clr_rx_nxt;
    logic [7:0]  tx_data_q, tx_data_nxt;
    logic        trmt_q, trmt_nxt;
    logic        sent_q, sent_nxt;
    logic        accept;
    logic        timeout;

    // clr_rx_rdy still high means the receiver has not yet dropped rx_rdy
    assign accept = bus.rx_rdy && !clr_rx_q;

`ifdef CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             frame_err_q;

    assign timeout = (cnt == CNT_LAST);

    always_comb begin
        cnt_nxt = cnt;
        if (rx_state == WAIT_HI) begin
            if (accept)
                cnt_nxt = '0;
        end else if (!accept) begin
            if (timeout)
                cnt_nxt = '0;
            else if (cnt != '1)
                cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            frame_err_q <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            frame_err_q <= (rx_state == WAIT_LO) && !accept && timeout;
        end
    end

    assign bus.frame_err = frame_err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES < 2);
    assign timeout            = 1'b0;
    assign bus.frame_err      = 1'b0;
`endif

    always_comb begin
        rx_state_nxt = rx_state;
        cmd_nxt      = cmd_q;
        cmd_rdy_nxt  = cmd_rdy_q;
        clr_rx_nxt   = 1'b0;
        if (bus.clr_cmd_rdy)
            cmd_rdy_nxt = 1'b0;
        unique case (rx_state)
            WAIT_HI: begin
                if (accept) begin
                    cmd_nxt[15:8] = bus.rx_data;
                    cmd_rdy_nxt   = 1'b0;
                    clr_rx_nxt    = 1'b1;
                    rx_state_nxt  = WAIT_LO;
                end
            end
            WAIT_LO: begin
                // low-byte completion overrides a same-cycle clr_cmd_rdy
                if (accept) begin
                    cmd_nxt[7:0] = bus.rx_data;
                    cmd_rdy_nxt  = 1'b1;
                    clr_rx_nxt   = 1'b1;
                    rx_state_nxt = WAIT_HI;
                end else if (timeout) begin
                    rx_state_nxt = WAIT_HI;
                end
            end
        endcase
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_data_nxt  = tx_data_q;
        trmt_nxt     = 1'b0;
        sent_nxt     = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                if (bus.send_resp) begin
                    tx_data_nxt  = bus.resp;
                    trmt_nxt     = 1'b1;
                    tx_state_nxt = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (bus.tx_done) begin
                    sent_nxt     = 1'b1;
                    tx_state_nxt = TX_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state  <= WAIT_HI;
            tx_state  <= TX_IDLE;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
            clr_rx_q  <= 1'b0;
            tx_data_q <= '0;
            trmt_q    <= 1'b0;
            sent_q    <= 1'b0;
        end else begin
            rx_state  <= rx_state_nxt;
            tx_state  <= tx_state_nxt;
            cmd_q     <= cmd_nxt;
            cmd_rdy_q <= cmd_rdy_nxt;
            clr_rx_q  <= clr_rx_nxt;
            tx_data_q <= tx_data_nxt;
            trmt_q    <= trmt_nxt;
            sent_q    <= sent_nxt;
        end
    end

    assign bus.cmd        = cmd_q;
    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.clr_rx_rdy = clr_rx_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.trmt       = trmt_q;
    assign bus.resp_sent  = sent_q;
endmodule
